// File: rtl/axi_arbiter_if.sv
// AXI-style bus bundle shared by the IFU, LSU and MEM ports of the arbiter.
// Channels: AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready),
//           AW (awaddr/awvalid/awready), W (wdata/wmask/wvalid/wready),
//           B (bresp/bvalid/bready).
// modport master : the side that issues requests (drives valids, address, data)
// modport slave  : the side that answers requests (drives readies and responses)
interface axi_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WMASK_W = 8
);
  logic [ADDR_W-1:0]  araddr;
  logic               arvalid;
  logic               arready;
  logic [DATA_W-1:0]  rdata;
  logic [1:0]         rresp;
  logic               rvalid;
  logic               rready;
  logic [ADDR_W-1:0]  awaddr;
  logic               awvalid;
  logic               awready;
  logic [DATA_W-1:0]  wdata;
  logic [WMASK_W-1:0] wmask;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wmask, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wmask, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_arbiter.sv
// 2:1 arbiter merging the IFU fetch master (read only) and the LSU master
// (read + write) onto the single MEM port. One transaction in flight at a time;
// the grant is held until its response handshake completes. LSU writes win,
// simultaneous reads alternate round-robin.
// Ports:
//   clk   - clock, everything on posedge
//   reset - asynchronous, active-high
//   ifu   - IFU master (AR/R only; AW/W/B answered with zeros)
//   lsu   - LSU master (AR/R/AW/W/B)
//   mem   - downstream memory slave
module axi_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WMASK_W = 8
) (
  input  logic   clk,
  input  logic   reset,
  axi_if.slave   ifu,
  axi_if.slave   lsu,
  axi_if.master  mem
);

  typedef enum logic [1:0] {IDLE, RD_IFU, RD_LSU, WR_LSU} state_t;

  state_t state_reg, state_next;
  logic   ar_done_reg, aw_done_reg, w_done_reg;
  logic   last_rd_reg;   // 1: LSU received the most recent read grant

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  // IFU write-side inputs are never routed anywhere.
  logic unused_ifu_wr;
  assign unused_ifu_wr = ^{ifu.awaddr, ifu.wdata, ifu.wmask, ifu.bready};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      ar_done_reg <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      last_rd_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      // Done flags keep a held-high valid from issuing a second request
      // inside the same grant; they are wiped whenever the grant ends.
      if (state_next == IDLE) begin
        ar_done_reg <= 1'b0;
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
      end else begin
        if (ar_hs) ar_done_reg <= 1'b1;
        if (aw_hs) aw_done_reg <= 1'b1;
        if (w_hs)  w_done_reg  <= 1'b1;
      end
      if (state_reg == IDLE && state_next == RD_IFU) last_rd_reg <= 1'b0;
      if (state_reg == IDLE && state_next == RD_LSU) last_rd_reg <= 1'b1;
    end
  end

  // Output routing: everything defaults to zero, the granted path is opened.
  always_comb begin
    mem.araddr  = {ADDR_W{1'b0}};
    mem.arvalid = 1'b0;
    mem.rready  = 1'b0;
    mem.awaddr  = {ADDR_W{1'b0}};
    mem.awvalid = 1'b0;
    mem.wdata   = {DATA_W{1'b0}};
    mem.wmask   = {WMASK_W{1'b0}};
    mem.wvalid  = 1'b0;
    mem.bready  = 1'b0;

    ifu.arready = 1'b0;
    ifu.rdata   = {DATA_W{1'b0}};
    ifu.rresp   = 2'b00;
    ifu.rvalid  = 1'b0;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bresp   = 2'b00;
    ifu.bvalid  = 1'b0;

    lsu.arready = 1'b0;
    lsu.rdata   = {DATA_W{1'b0}};
    lsu.rresp   = 2'b00;
    lsu.rvalid  = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bresp   = 2'b00;
    lsu.bvalid  = 1'b0;

    case (state_reg)
      RD_IFU: begin
        mem.araddr  = ifu.araddr;
        mem.arvalid = ifu.arvalid & ~ar_done_reg;
        ifu.arready = mem.arready & ~ar_done_reg;
        ifu.rvalid  = mem.rvalid;
        ifu.rdata   = mem.rdata;
        ifu.rresp   = mem.rresp;
        mem.rready  = ifu.rready;
      end
      RD_LSU: begin
        mem.araddr  = lsu.araddr;
        mem.arvalid = lsu.arvalid & ~ar_done_reg;
        lsu.arready = mem.arready & ~ar_done_reg;
        lsu.rvalid  = mem.rvalid;
        lsu.rdata   = mem.rdata;
        lsu.rresp   = mem.rresp;
        mem.rready  = lsu.rready;
      end
      WR_LSU: begin
        // AW and W are independent; either may finish first.
        mem.awaddr  = lsu.awaddr;
        mem.awvalid = lsu.awvalid & ~aw_done_reg;
        lsu.awready = mem.awready & ~aw_done_reg;
        mem.wdata   = lsu.wdata;
        mem.wmask   = lsu.wmask;
        mem.wvalid  = lsu.wvalid & ~w_done_reg;
        lsu.wready  = mem.wready & ~w_done_reg;
        lsu.bvalid  = mem.bvalid;
        lsu.bresp   = mem.bresp;
        mem.bready  = lsu.bready;
      end
      default: ;
    endcase
  end

  assign ar_hs = mem.arvalid & mem.arready;
  assign r_hs  = mem.rvalid  & mem.rready;
  assign aw_hs = mem.awvalid & mem.awready;
  assign w_hs  = mem.wvalid  & mem.wready;
  assign b_hs  = mem.bvalid  & mem.bready;

  // Next-state: the decision is registered, so a request seen in IDLE is
  // forwarded from the following cycle; a grant always returns through IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (lsu.awvalid | lsu.wvalid)
          state_next = WR_LSU;
        else if (ifu.arvalid && lsu.arvalid)
          state_next = last_rd_reg ? RD_IFU : RD_LSU;
        else if (ifu.arvalid)
          state_next = RD_IFU;
        else if (lsu.arvalid)
          state_next = RD_LSU;
      end
      RD_IFU, RD_LSU: if (r_hs) state_next = IDLE;
      WR_LSU:         if (b_hs) state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  // The fetch master never writes.
  ifu_no_write: assert property (@(posedge clk) disable iff (reset)
                                 !(ifu.awvalid || ifu.wvalid));

endmodule

// File: tb/tb_axi_arbiter.sv
module tb_axi_arbiter;

  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_if ifu_bus ();
  axi_if lsu_bus ();
  axi_if mem_bus ();

  axi_arbiter #(.ADDR_W(32), .DATA_W(32), .WMASK_W(8)) dut (
    .clk   (clk),
    .reset (rst),
    .ifu   (ifu_bus),
    .lsu   (lsu_bus),
    .mem   (mem_bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_A5A5;
  endfunction

  // ---------------- MEM slave environment ----------------
  logic [31:0] pmem [logic [29:0]];
  logic [31:0] ar_log [$];
  bit          ar_stall = 0;
  int          read_extra = 0;
  int          mem_wr_cnt = 0;
  int          mem_extra = 0;
  int          ar_at_wr = 0;
  int          lsu_rv_cnt = 0;

  logic        rd_pend, aw_got, w_got;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [7:0]  wr_mask;
  int          rd_wait;

  function automatic logic [31:0] mem_read(logic [31:0] a);
    if (pmem.exists(a[31:2])) return pmem[a[31:2]];
    return init_word(a);
  endfunction

  function automatic void mem_write(logic [31:0] a, logic [31:0] d, logic [7:0] m);
    logic [31:0] w;
    w = mem_read(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    pmem[a[31:2]] = w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_bus.arready <= 1'b0;
      mem_bus.rvalid  <= 1'b0;
      mem_bus.rdata   <= '0;
      mem_bus.rresp   <= 2'b00;
      mem_bus.awready <= 1'b0;
      mem_bus.wready  <= 1'b0;
      mem_bus.bvalid  <= 1'b0;
      mem_bus.bresp   <= 2'b00;
      rd_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      rd_addr <= '0; wr_addr <= '0; wr_data <= '0; wr_mask <= '0; rd_wait <= 0;
    end else begin
      // any new valid while a request of that kind is outstanding is a double issue
      if (((rd_pend || mem_bus.rvalid) && mem_bus.arvalid) ||
          ((aw_got || mem_bus.bvalid) && mem_bus.awvalid) ||
          ((w_got || mem_bus.bvalid) && mem_bus.wvalid))
        mem_extra <= mem_extra + 1;

      if (mem_bus.arvalid && mem_bus.arready) begin
        rd_pend <= 1'b1;
        rd_addr <= mem_bus.araddr;
        rd_wait <= $urandom_range(0, 2) + read_extra;
        mem_bus.arready <= 1'b0;
        ar_log.push_back(mem_bus.araddr);
      end else if (!rd_pend && !mem_bus.rvalid)
        mem_bus.arready <= !ar_stall && ($urandom_range(0, 1) == 1);
      if (rd_pend) begin
        if (rd_wait == 0) begin
          mem_bus.rvalid <= 1'b1;
          mem_bus.rdata  <= mem_read(rd_addr);
          rd_pend <= 1'b0;
        end else rd_wait <= rd_wait - 1;
      end
      if (mem_bus.rvalid && mem_bus.rready) begin
        mem_bus.rvalid <= 1'b0;
        mem_bus.rdata  <= '0;
      end

      if (mem_bus.awvalid && mem_bus.awready) begin
        aw_got <= 1'b1; wr_addr <= mem_bus.awaddr; mem_bus.awready <= 1'b0;
      end else if (!aw_got && !mem_bus.bvalid)
        mem_bus.awready <= ($urandom_range(0, 1) == 1);
      if (mem_bus.wvalid && mem_bus.wready) begin
        w_got <= 1'b1; wr_data <= mem_bus.wdata; wr_mask <= mem_bus.wmask; mem_bus.wready <= 1'b0;
      end else if (!w_got && !mem_bus.bvalid)
        mem_bus.wready <= ($urandom_range(0, 1) == 1);
      if (aw_got && w_got && !mem_bus.bvalid) begin
        mem_write(wr_addr, wr_data, wr_mask);
        mem_bus.bvalid <= 1'b1;
        aw_got <= 1'b0; w_got <= 1'b0;
        mem_wr_cnt <= mem_wr_cnt + 1;
        ar_at_wr <= ar_log.size();
      end
      if (mem_bus.bvalid && mem_bus.bready) mem_bus.bvalid <= 1'b0;
    end
  end

  always @(posedge clk) if (lsu_bus.rvalid) lsu_rv_cnt <= lsu_rv_cnt + 1;

  // ---------------- reference model (spec-level) ----------------
  logic [31:0] ref_mem [logic [29:0]];
  bit          ref_last_lsu = 1;   // after reset LSU counts as last read winner

  function automatic logic [31:0] ref_read(logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return init_word(a);
  endfunction

  function automatic void ref_write(logic [31:0] a, logic [31:0] d, logic [7:0] m);
    logic [31:0] w;
    w = ref_read(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a[31:2]] = w;
  endfunction

  function automatic logic [14:0] hs_vec();
    return {mem_bus.arvalid, mem_bus.rready, mem_bus.awvalid, mem_bus.wvalid, mem_bus.bready,
            ifu_bus.arready, ifu_bus.rvalid, ifu_bus.awready, ifu_bus.wready, ifu_bus.bvalid,
            lsu_bus.arready, lsu_bus.rvalid, lsu_bus.awready, lsu_bus.wready, lsu_bus.bvalid};
  endfunction

  // ---------------- master drivers ----------------
  task automatic ifu_read(input logic [31:0] addr, input bit hold,
                          output logic [31:0] data, output bit ok);
    bit ar_seen, done, hs_ar;
    int n;
    ar_seen = 0; done = 0; n = 0; data = '0;
    ifu_bus.araddr = addr; ifu_bus.arvalid = 1'b1; ifu_bus.rready = 1'b1;
    while (!done && n < TMO) begin
      @(negedge clk);
      hs_ar = ifu_bus.arvalid && ifu_bus.arready;
      if (ifu_bus.rvalid) begin data = ifu_bus.rdata; done = 1; end
      @(posedge clk); #1;
      if (hs_ar) ar_seen = 1;
      if (ar_seen && !hold) ifu_bus.arvalid = 1'b0;
      n++;
    end
    ifu_bus.arvalid = 1'b0; ifu_bus.rready = 1'b0; ok = done;
  endtask

  task automatic lsu_read(input logic [31:0] addr, input bit hold,
                          output logic [31:0] data, output bit ok);
    bit ar_seen, done, hs_ar;
    int n;
    ar_seen = 0; done = 0; n = 0; data = '0;
    lsu_bus.araddr = addr; lsu_bus.arvalid = 1'b1; lsu_bus.rready = 1'b1;
    while (!done && n < TMO) begin
      @(negedge clk);
      hs_ar = lsu_bus.arvalid && lsu_bus.arready;
      if (lsu_bus.rvalid) begin data = lsu_bus.rdata; done = 1; end
      @(posedge clk); #1;
      if (hs_ar) ar_seen = 1;
      if (ar_seen && !hold) lsu_bus.arvalid = 1'b0;
      n++;
    end
    lsu_bus.arvalid = 1'b0; lsu_bus.rready = 1'b0; ok = done;
  endtask

  task automatic lsu_write(input logic [31:0] addr, input logic [31:0] d, input logic [7:0] m,
                           input int aw_d, input int w_d, input bit hold, output bit ok);
    bit aw_ok, w_ok, b_ok, haw, hw, hb;
    int n;
    aw_ok = 0; w_ok = 0; b_ok = 0; n = 0;
    lsu_bus.awaddr = addr; lsu_bus.wdata = d; lsu_bus.wmask = m; lsu_bus.bready = 1'b1;
    while (!b_ok && n < TMO) begin
      if (n == aw_d && !aw_ok) lsu_bus.awvalid = 1'b1;
      if (n == w_d && !w_ok)   lsu_bus.wvalid  = 1'b1;
      @(negedge clk);
      haw = lsu_bus.awvalid && lsu_bus.awready;
      hw  = lsu_bus.wvalid && lsu_bus.wready;
      hb  = lsu_bus.bvalid;
      @(posedge clk); #1;
      if (haw) aw_ok = 1;
      if (hw)  w_ok = 1;
      if (hb)  b_ok = 1;
      if (aw_ok && !hold) lsu_bus.awvalid = 1'b0;
      if (w_ok && !hold)  lsu_bus.wvalid  = 1'b0;
      n++;
    end
    lsu_bus.awvalid = 1'b0; lsu_bus.wvalid = 1'b0; lsu_bus.bready = 1'b0;
    ok = aw_ok && w_ok && b_ok;
  endtask

  // One round: optional IFU read plus optional LSU op (0 none, 1 read, 2 write),
  // all launched in the same cycle from idle. Expectations come from the model.
  task automatic round(input string tag, input bit do_ifu, input logic [31:0] ia,
                       input int lop, input logic [31:0] la, input logic [31:0] wd,
                       input logic [7:0] wm, input int aw_d, input int w_d, input bit hold,
                       output logic [31:0] got_i);
    logic [31:0] exp_i, exp_l, got_l, first_exp;
    bit ok_i, ok_l, tie;
    int wr0, ex0, nrd;
    ok_i = 1; ok_l = 1; got_l = '0; got_i = '0;
    if (lop == 2) ref_write(la, wd, wm);   // writes are granted ahead of a same-cycle read
    exp_i = ref_read(ia);
    exp_l = ref_read(la);
    tie = do_ifu && (lop == 1);
    first_exp = ref_last_lsu ? ia : la;
    if (!tie && do_ifu) ref_last_lsu = 0;
    else if (!tie && lop == 1) ref_last_lsu = 1;
    nrd = int'(do_ifu) + ((lop == 1) ? 1 : 0);
    wr0 = mem_wr_cnt; ex0 = mem_extra;
    ar_log.delete();
    fork
      begin if (do_ifu) ifu_read(ia, hold, got_i, ok_i); end
      begin
        if (lop == 1) lsu_read(la, hold, got_l, ok_l);
        else if (lop == 2) lsu_write(la, wd, wm, aw_d, w_d, hold, ok_l);
      end
    join
    @(negedge clk);
    if (do_ifu) begin
      check({tag, "_ifu_done"}, 64'(ok_i), 64'd1);
      check({tag, "_ifu_rdata"}, 64'(got_i), 64'(exp_i));
    end
    if (lop == 1) begin
      check({tag, "_lsu_done"}, 64'(ok_l), 64'd1);
      check({tag, "_lsu_rdata"}, 64'(got_l), 64'(exp_l));
    end
    if (lop == 2) begin
      check({tag, "_wr_done"}, 64'(ok_l), 64'd1);
      check({tag, "_wr_count"}, 64'(mem_wr_cnt - wr0), 64'd1);
      if (do_ifu) check({tag, "_wr_before_rd"}, 64'(ar_at_wr), 64'd0);
    end
    check({tag, "_ar_count"}, 64'(ar_log.size()), 64'(nrd));
    if (tie && ar_log.size() > 0) check({tag, "_tie_winner"}, 64'(ar_log[0]), 64'(first_exp));
    check({tag, "_double_issue"}, 64'(mem_extra - ex0), 64'd0);
    check({tag, "_idle_quiet"}, 64'(hs_vec()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ref_last_lsu = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit ok;
    int rv0, n, lop, awd, wdl;
    logic [31:0] ia, la;

    ifu_bus.araddr = '0; ifu_bus.arvalid = 0; ifu_bus.rready = 0;
    ifu_bus.awaddr = '0; ifu_bus.awvalid = 0; ifu_bus.wdata = '0; ifu_bus.wmask = '0;
    ifu_bus.wvalid = 0; ifu_bus.bready = 0;
    lsu_bus.araddr = '0; lsu_bus.arvalid = 0; lsu_bus.rready = 0;
    lsu_bus.awaddr = '0; lsu_bus.awvalid = 0; lsu_bus.wdata = '0; lsu_bus.wmask = '0;
    lsu_bus.wvalid = 0; lsu_bus.bready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_hs_zero", 64'(hs_vec()), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_hs_zero", 64'(hs_vec()), 64'd0);
    check("idle_payload_zero", {mem_bus.araddr, mem_bus.wdata}, 64'd0);
    @(posedge clk); #1;

    // 1: lone IFU read; forwarding starts one cycle after the request
    rv0 = lsu_rv_cnt;
    ar_stall = 1;
    ifu_bus.araddr = 32'h8000_0000; ifu_bus.arvalid = 1'b1; ifu_bus.rready = 1'b1;
    @(negedge clk);
    check("t1_first_cycle_idle", 64'(mem_bus.arvalid), 64'd0);
    @(negedge clk);
    check("t1_arvalid_next", 64'(mem_bus.arvalid), 64'd1);
    check("t1_araddr", 64'(mem_bus.araddr), 64'h8000_0000);
    @(posedge clk); #1;
    ar_stall = 0;
    ifu_read(32'h8000_0000, 0, d, ok);
    check("t1_done", 64'(ok), 64'd1);
    check("t1_rdata", 64'(d), 64'(ref_read(32'h8000_0000)));
    check("t1_lsu_no_rvalid", 64'(lsu_rv_cnt - rv0), 64'd0);

    // 2: ties right after reset -> IFU, LSU; second tie IFU again
    pulse_reset();
    round("t2a", 1, 32'h8000_0000, 1, 32'h8000_0100, '0, '0, 0, 0, 0, d);
    round("t2b", 1, 32'h8000_0004, 1, 32'h8000_0104, '0, '0, 0, 0, 0, d);

    // 3: write wins over pending fetch, fetch sees the new word
    round("t3", 1, 32'h8000_0010, 2, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 0, 0, d);
    check("t3_deadbeef", 64'(d), 64'hDEAD_BEEF);

    // 4: AW three cycles ahead of W, then W ahead of AW
    round("t4a", 0, 32'h8000_0000, 2, 32'h8000_0020, 32'h1234_5678, 8'h0F, 0, 3, 0, d);
    round("t4b", 0, 32'h8000_0000, 2, 32'h8000_0024, 32'hCAFE_F00D, 8'h05, 3, 0, 0, d);

    // 5: masters keep valid high until the response
    round("t5a", 1, 32'h8000_0020, 1, 32'h8000_0030, '0, '0, 0, 0, 1, d);
    round("t5b", 0, 32'h8000_0000, 2, 32'h8000_0028, 32'hA5A5_0F0F, 8'h0F, 1, 0, 1, d);

    // randomized rounds
    for (int r = 0; r < 30; r++) begin
      ia  = 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
      la  = 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
      lop = $urandom_range(0, 2);
      awd = $urandom_range(0, 3);
      wdl = $urandom_range(0, 3);
      n   = $urandom_range(0, 1);
      if (lop == 0) n = 1;
      if (n == 1 && lop == 1 && la == ia) la = la ^ 32'h40;
      if (n == 1 && lop == 2) wdl = 0;
      round($sformatf("rnd%0d", r), n[0], ia, lop, la, $urandom, 8'($urandom_range(0, 15)),
            awd, wdl, $urandom_range(0, 1) == 1, d);
    end

    // 6: reset while RD_LSU waits on rvalid
    read_extra = 20;
    lsu_bus.araddr = 32'h8000_0008; lsu_bus.arvalid = 1'b1; lsu_bus.rready = 1'b1;
    ok = 0;
    for (int i = 0; i < TMO && !ok; i++) begin
      @(negedge clk);
      ok = lsu_bus.arvalid && lsu_bus.arready;
      @(posedge clk); #1;
    end
    check("t6_ar_accepted", 64'(ok), 64'd1);
    lsu_bus.arvalid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_reset_hs_zero", 64'(hs_vec()), 64'd0);
    lsu_bus.rready = 1'b0;
    read_extra = 0;
    @(negedge clk);
    rst = 1'b0;
    ref_last_lsu = 1;
    @(posedge clk); #1;
    round("t6_fresh", 1, 32'h8000_0040, 0, 32'h8000_0000, '0, '0, 0, 0, 0, d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
